spi_to_uart_camp2: RTL and testbench
====================================

# spi_to_uart_camp2

Bridge between a dual-channel SPI ADC controller and a byte-wide UART transmitter. It repeatedly requests a conversion, captures two 12-bit samples plus two pulse-event counts, and streams them as a fixed 7-byte frame. It sits between the SPI ADC master (`start`/`done`/`data1`/`data2`) and the UART TX core (`TxD_start`/`TxD_data`/`TxD_busy`).

## Interface
- Single clock `clk`. Reset `rst` is synchronous and active-low.
- `GAP_CYCLES`, default 16: idle cycles between the end of one frame and the next `start`. Minimum 1.
- `HEADER`, default 8'hA5: first byte of every frame.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous active-low reset.
- `data1`  in  12  channel-1 ADC result; valid while `done`=1.
- `data2`  in  12  channel-2 ADC result; valid while `done`=1.
- `done`  in  1  ADC controller conversion complete.
- `TxD_start`  out  1  one-cycle request to UART to send `TxD_data`.
- `TxD_data`  out  8  byte to transmit.
- `start`  out  1  one-cycle conversion request to the ADC controller.
- `TxD_busy`  in  1  UART is transmitting; high = cannot accept.
- `Pulse1_in`  in  1  asynchronous event input 1.
- `Pulse2_in`  in  1  asynchronous event input 2.

## Operation
- Pulse inputs:
  - Each passes through a 2-FF synchronizer and a rising-edge detector.
  - Each edge increments an 8-bit counter (`cnt1`/`cnt2`) that saturates at 255.
- FSM states: IDLE, START, WAIT_DONE, LATCH, SEND, WAIT_TX.
- IDLE: count `GAP_CYCLES` cycles, then go to START.
- START: `start`=1 for exactly one cycle, then go to WAIT_DONE.
- WAIT_DONE: wait for `done`=1. `done` already high on entry counts. No timeout.
- LATCH (one cycle):
  - Register `data1`, `data2`, `cnt1`, `cnt2` into frame registers.
  - Clear both counters in the same cycle. An edge detected in that cycle counts as 1 in the new window.
- Frame byte order (index 0–6): `HEADER`, {4'h0,d1[11:8]}, d1[7:0], {4'h0,d2[11:8]}, d2[7:0], cnt1, cnt2.
- SEND:
  - While `TxD_busy`=1, hold.
  - When `TxD_busy`=0, drive `TxD_data`=byte[idx] with `TxD_start`=1 for one cycle, then go to WAIT_TX.
- WAIT_TX:
  - Mandatory one-cycle guard so the UART can raise busy.
  - Then increment idx. If idx was 6, go to IDLE; otherwise go to SEND.
- `TxD_data` holds its last value when `TxD_start`=0.
- `data1`/`data2` changes after LATCH do not affect the frame in flight.

## Timing
- Reset values: `start`=0, `TxD_start`=0, `TxD_data`=8'h00, counters 0, idx 0, state IDLE, gap counter 0.
- Reset asserted mid-frame aborts the frame immediately; no partial byte is re-sent after release.
- First `start`: `GAP_CYCLES`+1 cycles after the first rising edge with `rst`=1.
- `done`→`TxD_start` latency with `TxD_busy`=0: done seen in WAIT_DONE, LATCH next cycle, SEND next → first `TxD_start` 2 cycles after the `done` sample.
- Byte spacing with `TxD_busy` always 0: 2 cycles (SEND, WAIT_TX); a frame takes 14 cycles.
- Pulse edge to counter update: 3 cycles (2 sync + edge register).
- A pulse must be high ≥2 clocks and low ≥2 clocks to be counted reliably.
- `start` and `TxD_start` are never high together.

## Structure
- Shared package holds the state enum, `HEADER`, and `FRAME_LEN`=7.
- One sub-module, `pulse_counter`: synchronizer, edge detect, saturating 8-bit count, synchronous clear input. Instantiate it twice.
- FSM and frame mux live in the top module.

## Test plan
- Reset held low 3 cycles with random inputs:
  - All outputs 0.
  - After release, `start` pulses once at cycle `GAP_CYCLES`+1.
- `done`=1 with `data1`=12'h3A7, `data2`=12'h05C, `TxD_busy`=0, no pulses:
  - Bytes A5, 03, A7, 00, 5C, 00, 00 at 2-cycle spacing.
- 5 pulses on `Pulse1_in` and 300 on `Pulse2_in` before `done`:
  - cnt bytes 05, FF.
  - Next frame's counts start from 0.
- `TxD_busy` held high 20 cycles before byte 2:
  - No `TxD_start` while busy.
  - Byte 2 sent on the first cycle busy is low; no byte lost or duplicated.
- `done` delayed 50 cycles after `start`:
  - FSM waits, no UART activity.
  - `data1` changed after LATCH does not alter the frame.
- `rst` asserted during byte 3:
  - Outputs return to reset values next cycle.
  - A fresh frame starting with A5 follows the next `done`.

Source files
------------

// File: rtl/spi_to_uart_camp2_pkg.sv
// spi_to_uart_camp2_pkg: shared state encoding and frame constants for the ADC-to-UART bridge
package spi_to_uart_camp2_pkg;
    typedef enum logic [2:0] {IDLE, START, WAIT_DONE, LATCH, SEND, WAIT_TX} state_t;
    localparam logic [7:0] HEADER = 8'hA5;
    localparam int FRAME_LEN = 7;
endpackage

// File: rtl/spi_to_uart_camp2_pulse_counter.sv
// pulse_counter: synchronises an async pulse, detects rising edges and counts them saturating at 255
module pulse_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       pulse,
    input  logic       clr,
    output logic [7:0] count
);
    logic [2:0] sync;
    logic       rise;
    assign rise = sync[1] & ~sync[2];
    // two-stage synchroniser plus edge register; a clear restarts the window but keeps a same-cycle edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync  <= '0;
            count <= '0;
        end else begin
            sync  <= {sync[1:0], pulse};
            count <= clr ? {7'd0, rise} : (rise && count != 8'hFF) ? count + 8'd1 : count;
        end
    end
endmodule

// File: rtl/spi_to_uart_camp2.sv
// spi_to_uart_camp2: requests ADC conversions and streams two samples plus pulse counts as 7-byte UART frames
module spi_to_uart_camp2
    import spi_to_uart_camp2_pkg::*;
#(
    parameter int         GAP_CYCLES = 16,
    parameter logic [7:0] HEADER     = spi_to_uart_camp2_pkg::HEADER
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] data1,
    input  logic [11:0] data2,
    input  logic        done,
    output logic        TxD_start,
    output logic [7:0]  TxD_data,
    output logic        start,
    input  logic        TxD_busy,
    input  logic        Pulse1_in,
    input  logic        Pulse2_in
);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    state_t         state, nxt;
    logic [GW-1:0]  gap;
    logic [2:0]     idx;
    logic [11:0]    d1, d2;
    logic [7:0]     c1, c2, cnt1, cnt2, last, byte_sel;
    logic           clr;
    assign start     = state == START;
    assign TxD_start = state == SEND && !TxD_busy;
    assign clr       = state == LATCH;
    assign TxD_data  = TxD_start ? byte_sel : last;
    pulse_counter u_cnt1 (.clk(clk), .rst(rst), .pulse(Pulse1_in), .clr(clr), .count(cnt1));
    pulse_counter u_cnt2 (.clk(clk), .rst(rst), .pulse(Pulse2_in), .clr(clr), .count(cnt2));
    // frame byte selected by the current index
    always_comb begin
        byte_sel = idx == 3'd0 ? HEADER :
                   idx == 3'd1 ? {4'h0, d1[11:8]} :
                   idx == 3'd2 ? d1[7:0] :
                   idx == 3'd3 ? {4'h0, d2[11:8]} :
                   idx == 3'd4 ? d2[7:0] :
                   idx == 3'd5 ? c1 : c2;
    end
    // next-state logic for the conversion/transmit sequence
    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = gap == GW'(GAP_CYCLES) ? START : IDLE;
            START:     nxt = WAIT_DONE;
            WAIT_DONE: nxt = done ? LATCH : WAIT_DONE;
            LATCH:     nxt = SEND;
            SEND:      nxt = TxD_busy ? SEND : WAIT_TX;
            WAIT_TX:   nxt = idx == 3'(FRAME_LEN - 1) ? IDLE : SEND;
            default:   nxt = IDLE;
        endcase
    end
    // state, gap timer, byte index, held UART byte and frame snapshot registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            gap   <= '0;
            idx   <= '0;
            last  <= '0;
            d1    <= '0;
            d2    <= '0;
            c1    <= '0;
            c2    <= '0;
        end else begin
            state <= nxt;
            gap   <= (state == IDLE && gap != GW'(GAP_CYCLES)) ? gap + 1'b1 : '0;
            idx   <= state != WAIT_TX ? idx : idx == 3'(FRAME_LEN - 1) ? 3'd0 : idx + 3'd1;
            if (TxD_start) last <= byte_sel;
            if (clr) begin
                d1 <= data1;
                d2 <= data2;
                c1 <= cnt1;
                c2 <= cnt2;
            end
        end
    end
endmodule

// File: tb/tb_spi_to_uart_camp2.sv
// tb_spi_to_uart_camp2: directed self-checking bench for the ADC-to-UART frame bridge
module tb_spi_to_uart_camp2;
    localparam int G = 16;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] data1 = '0, data2 = '0;
    logic        done = 1'b0, TxD_busy = 1'b0, Pulse1_in = 1'b0, Pulse2_in = 1'b0;
    logic        TxD_start, start;
    logic [7:0]  TxD_data;
    int          checks = 0;
    int          errors = 0;

    spi_to_uart_camp2 #(.GAP_CYCLES(G)) dut (
        .clk(clk), .rst(rst), .data1(data1), .data2(data2), .done(done),
        .TxD_start(TxD_start), .TxD_data(TxD_data), .start(start),
        .TxD_busy(TxD_busy), .Pulse1_in(Pulse1_in), .Pulse2_in(Pulse2_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // start and TxD_start must never overlap
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            assert ((start & TxD_start) !== 1'b1) else begin
                errors++;
                $error("FAIL excl: got start=%0b TxD_start=%0b expected not both 1", start, TxD_start);
            end
        end
    end

    task automatic reset_and_check();
        rst = 1'b0;
        repeat (3) begin
            data1 = 12'($urandom); data2 = 12'($urandom); done = 1'($urandom);
            TxD_busy = 1'($urandom); Pulse1_in = 1'($urandom); Pulse2_in = 1'($urandom);
            @(posedge clk); #1;
            chk("rst_start", start, 0);
            chk("rst_txs", TxD_start, 0);
            chk("rst_txd", TxD_data, 0);
        end
        data1 = '0; data2 = '0; done = 0; TxD_busy = 0; Pulse1_in = 0; Pulse2_in = 0;
        rst = 1'b1;
        for (int i = 0; i <= G; i++) begin
            @(posedge clk); #1;
            chk("first_start", start, i == G);
        end
    endtask

    task automatic after_start();
        @(posedge clk); #1;
        chk("start_one", start, 0);
    endtask

    task automatic wait_conv();
        bit found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk); #1;
            found = start;
        end
        chk("start_seen", found, 1);
        after_start();
    endtask

    task automatic give_done(input logic [11:0] a, input logic [11:0] b);
        data1 = a; data2 = b; done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
    endtask

    task automatic pulses(input int n1, input int n2);
        for (int i = 0; i < n2; i++) begin
            Pulse2_in = 1'b1; Pulse1_in = i < n1;
            repeat (2) begin @(posedge clk); #1; end
            Pulse2_in = 1'b0; Pulse1_in = 1'b0;
            repeat (2) begin @(posedge clk); #1; end
        end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input logic [55:0] exp, input int busy_idx, input int rst_idx, input bit chg);
        for (int i = 0; i < 7; i++) begin
            logic [7:0] b;
            b = exp[55-8*i -: 8];
            if (i == busy_idx) begin
                TxD_busy = 1'b1;
                repeat (20) begin
                    @(posedge clk); #1;
                    chk("busy_hold", TxD_start, 0);
                end
                TxD_busy = 1'b0;
                #1;
            end else begin
                @(posedge clk); #1;
            end
            chk($sformatf("txs_b%0d", i), TxD_start, 1);
            chk($sformatf("data_b%0d", i), TxD_data, b);
            if (chg && i == 0) data1 = 12'h000;
            if (i == rst_idx) begin
                rst = 1'b0;
                @(posedge clk); #1;
                chk("abort_start", start, 0);
                chk("abort_txs", TxD_start, 0);
                chk("abort_txd", TxD_data, 0);
                return;
            end
            @(posedge clk); #1;
            chk($sformatf("guard_b%0d", i), TxD_start, 0);
            chk($sformatf("hold_b%0d", i), TxD_data, b);
        end
    endtask

    initial begin
        reset_and_check();
        after_start();
        give_done(12'h3A7, 12'h05C);
        send_frame(56'hA5_03_A7_00_5C_00_00, -1, -1, 0);
        wait_conv();
        pulses(5, 300);
        give_done(12'h123, 12'h456);
        send_frame(56'hA5_01_23_04_56_05_FF, -1, -1, 0);
        wait_conv();
        repeat (50) begin
            @(posedge clk); #1;
            chk("no_uart", TxD_start, 0);
        end
        give_done(12'h7FF, 12'h001);
        send_frame(56'hA5_07_FF_00_01_00_00, -1, -1, 1);
        wait_conv();
        give_done(12'hABC, 12'hDEF);
        send_frame(56'hA5_0A_BC_0D_EF_00_00, 2, -1, 0);
        wait_conv();
        give_done(12'h111, 12'h222);
        send_frame(56'hA5_01_11_02_22_00_00, -1, 3, 0);
        reset_and_check();
        after_start();
        give_done(12'hFFF, 12'h800);
        send_frame(56'hA5_0F_FF_08_00_00_00, -1, -1, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
